regfile_debug_ctrl: RTL and testbench
=====================================

# regfile_debug_ctrl

Parametrised register-file test controller that sits between the CPU's register file debug ports and the surrounding bench or board logic. It replaces hand-written preload, run and dump sequences with one reusable sequence: it preloads every register with a selectable pattern, releases the CPU for a programmable number of cycles, then freezes the CPU and streams every register out over a valid/ready channel. It is synthesisable, so the same sequence runs in simulation and on hardware.

## Interface
Parameters:
- REGISTERS, 32, number of registers in the register file (>= 2)
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, $clog2(REGISTERS), register address width
- RUN_WIDTH, 16, width of the run-cycle count

Ports:
- Clock  in  1  system clock; all state changes on the rising edge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  begin a sequence; sampled only in IDLE or DONE
- Mode  in  2  preload pattern: 0 = index (reg[i] = i), 1 = zero, 2 = Seed + i, 3 = no preload
- Seed  in  DATA_WIDTH  base value for Mode 2
- RunCycles  in  RUN_WIDTH  number of CPU cycles to run
- CpuHold  out  1  1 = CPU stalled (no PC or register-file update)
- RfWriteEnable  out  1  debug write strobe to the register file
- RfWriteAddr  out  ADDR_WIDTH  debug write address
- RfWriteData  out  DATA_WIDTH  debug write data
- RfReadAddr  out  ADDR_WIDTH  debug read address (combinational read port)
- RfReadData  in  DATA_WIDTH  debug read data, valid in the same cycle as RfReadAddr
- DumpValid  out  1  dump word available
- DumpReady  in  1  consumer accepts dump word
- DumpIndex  out  ADDR_WIDTH  register index of the current dump word
- DumpData  out  DATA_WIDTH  register contents (driven directly from RfReadData)
- Busy  out  1  high in INIT, RUN and DUMP
- Done  out  1  high in DONE

## Operation
- States: IDLE, INIT, RUN, DUMP, DONE. Outputs are decoded from the state and the registered counters (Moore).
- IDLE/DONE + Start=1 -> capture Mode, Seed and RunCycles. Clear the index counter. Go to INIT, or to RUN if Mode=3.
- Start is ignored while Busy. A Start in DONE restarts the full sequence.
- INIT:
  - CpuHold=1, RfWriteEnable=1, RfWriteAddr=idx, RfWriteData=pattern(idx).
  - idx increments each cycle. After the write at idx = REGISTERS-1, clear the cycle counter and go to RUN.
- Pattern arithmetic:
  - Index pattern: idx zero-extended to DATA_WIDTH.
  - Seed pattern: Seed + idx, modulo 2^DATA_WIDTH (wraps, no saturation).
- RUN:
  - CpuHold=0 for exactly the captured RunCycles cycles, then go to DUMP with idx=0.
  - Captured RunCycles = 0: RUN lasts 0 cycles; INIT (or IDLE) goes directly to DUMP.
- DUMP:
  - CpuHold=1, DumpValid=1, RfReadAddr=DumpIndex=idx, DumpData=RfReadData.
  - A transfer happens on DumpValid & DumpReady, and idx increments on that transfer.
  - The transfer at idx = REGISTERS-1 goes to DONE.
  - If DumpReady is low, idx holds and all outputs stay stable.
- DONE: CpuHold=1 (register state frozen for inspection), Done=1, DumpValid=0.
- Register 0 is written like any other register. A hardwired-zero register file ignores the write, and the dump reports whatever the register file returns.

## Timing
- Reset values: state IDLE; CpuHold=0 (CPU runs freely when the block is unused); RfWriteEnable=0; DumpValid=0; Busy=0; Done=0; RfWriteAddr=RfReadAddr=DumpIndex=0; RfWriteData=0.
- Reset asserted mid-sequence: returns to IDLE at the next edge and aborts the sequence. No partial-write cleanup is done.
- Start sampled on edge T -> first write (idx 0) on edge T+1. INIT occupies REGISTERS cycles.
- Total latency from Start to first DumpValid: REGISTERS + RunCycles + 1 cycles (Mode 0-2); RunCycles + 1 cycles (Mode 3).
- Dump throughput: one word per cycle while DumpReady=1.
- Last transfer on edge E -> Done=1 and Busy=0 in the cycle after E.
- RunCycles counter has RUN_WIDTH bits. The maximum value 2^RUN_WIDTH-1 must run fully without the counter wrapping early.

## Test plan
- Mode 0, REGISTERS=32, RunCycles=0, DumpReady=1 -> 32 writes reg[i]=i on consecutive cycles. The dump then returns DumpIndex 0..31 with DumpData=i, and Done rises 65 cycles after Start.
- Mode 2, Seed=32'hFFFF_FFF0, DATA_WIDTH=32 -> reg[15]=32'hFFFF_FFFF and reg[16]=0 (wrap). The dump reports the same values.
- Mode 3, RunCycles=6, with a stub CPU that increments reg[1] while not held -> no writes. CpuHold is low for exactly 6 cycles, and the dump shows reg[1] advanced by 6.
- DumpReady toggled 1,0,0,1,… during DUMP -> no word lost or duplicated, and DumpIndex/DumpData stay stable while stalled. All 32 words are received in order.
- Reset pulsed for one cycle during RUN -> next cycle shows state IDLE, CpuHold=0, Busy=0. Start pulsed high during RUN (no reset) -> ignored, and the sequence completes unchanged.
- Start held high in DONE -> the sequence restarts with newly captured Mode, Seed and RunCycles. Done drops the cycle after Start.

Source files
------------

// File: rtl/regfile_debug_ctrl.sv
// Register-file test controller: preloads a pattern, runs the CPU for a set
// number of cycles, then freezes it and streams every register out.
module regfile_debug_ctrl #(
    parameter int REGISTERS  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = $clog2(REGISTERS),
    parameter int RUN_WIDTH  = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [1:0]            Mode,
    input  logic [DATA_WIDTH-1:0] Seed,
    input  logic [RUN_WIDTH-1:0]  RunCycles,
    output logic                  CpuHold,
    output logic                  RfWriteEnable,
    output logic [ADDR_WIDTH-1:0] RfWriteAddr,
    output logic [DATA_WIDTH-1:0] RfWriteData,
    output logic [ADDR_WIDTH-1:0] RfReadAddr,
    input  logic [DATA_WIDTH-1:0] RfReadData,
    output logic                  DumpValid,
    input  logic                  DumpReady,
    output logic [ADDR_WIDTH-1:0] DumpIndex,
    output logic [DATA_WIDTH-1:0] DumpData,
    output logic                  Busy,
    output logic                  Done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_t;

    localparam logic [1:0]            MODE_INDEX = 2'd0;
    localparam logic [1:0]            MODE_SEED  = 2'd2;
    localparam logic [1:0]            MODE_NONE  = 2'd3;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(REGISTERS - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE    = ADDR_WIDTH'(1);
    localparam logic [RUN_WIDTH-1:0]  RUN_ONE    = RUN_WIDTH'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [RUN_WIDTH-1:0]  run_cnt_q, run_cnt_d;
    logic [RUN_WIDTH-1:0]  run_cycles_q, run_cycles_d;
    logic [1:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic [DATA_WIDTH-1:0] pattern;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pattern = '0;
        case (mode_q)
            MODE_INDEX: pattern = DATA_WIDTH'(idx_q);
            MODE_SEED:  pattern = seed_q + DATA_WIDTH'(idx_q);
            default:    pattern = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        run_cnt_d    = run_cnt_q;
        run_cycles_d = run_cycles_q;
        mode_d       = mode_q;
        seed_d       = seed_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    mode_d       = Mode;
                    seed_d       = Seed;
                    run_cycles_d = RunCycles;
                    idx_d        = '0;
                    run_cnt_d    = '0;
                    if (Mode != MODE_NONE) begin
                        state_d = S_INIT;
                    end else if (RunCycles == '0) begin
                        state_d = S_DUMP;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_INIT: begin
                if (idx_q == LAST_IDX) begin
                    idx_d     = '0;
                    run_cnt_d = '0;
                    state_d   = (run_cycles_q == '0) ? S_DUMP : S_RUN;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            S_RUN: begin
                // RUN is only entered with a non-zero count, so the decrement cannot wrap.
                if (run_cnt_q == run_cycles_q - RUN_ONE) begin
                    idx_d   = '0;
                    state_d = S_DUMP;
                end else begin
                    run_cnt_d = run_cnt_q + RUN_ONE;
                end
            end
            S_DUMP: begin
                if (DumpReady) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        CpuHold       = 1'b0;
        RfWriteEnable = 1'b0;
        RfWriteAddr   = '0;
        RfWriteData   = '0;
        RfReadAddr    = '0;
        DumpValid     = 1'b0;
        DumpIndex     = '0;
        Busy          = 1'b0;
        Done          = 1'b0;
        case (state_q)
            S_INIT: begin
                CpuHold       = 1'b1;
                RfWriteEnable = 1'b1;
                RfWriteAddr   = idx_q;
                RfWriteData   = pattern;
                Busy          = 1'b1;
            end
            S_RUN: Busy = 1'b1;
            S_DUMP: begin
                CpuHold    = 1'b1;
                DumpValid  = 1'b1;
                RfReadAddr = idx_q;
                DumpIndex  = idx_q;
                Busy       = 1'b1;
            end
            S_DONE: begin
                CpuHold = 1'b1;
                Done    = 1'b1;
            end
            default: ;
        endcase
    end

    assign DumpData = RfReadData;

    always_ff @(posedge Clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (Reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            run_cnt_q    <= '0;
            run_cycles_q <= '0;
            mode_q       <= '0;
            seed_q       <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            run_cnt_q    <= run_cnt_d;
            run_cycles_q <= run_cycles_d;
            mode_q       <= mode_d;
            seed_q       <= seed_d;
        end
    end

endmodule

// File: tb/tb_regfile_debug_ctrl.sv
// Bench for regfile_debug_ctrl: behavioural register file with a stub CPU,
// directed sequences and a queue-based dump scoreboard.
module tb_regfile_debug_ctrl;

    localparam int REGS = 32;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int RW   = 16;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Start;
    logic [1:0]    Mode;
    logic [DW-1:0] Seed;
    logic [RW-1:0] RunCycles;
    logic          CpuHold;
    logic          RfWriteEnable;
    logic [AW-1:0] RfWriteAddr;
    logic [DW-1:0] RfWriteData;
    logic [AW-1:0] RfReadAddr;
    logic [DW-1:0] RfReadData;
    logic          DumpValid;
    logic          DumpReady;
    logic [AW-1:0] DumpIndex;
    logic [DW-1:0] DumpData;
    logic          Busy;
    logic          Done;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } dump_t;

    dump_t         sb[$];
    logic [DW-1:0] rf [REGS];
    logic          cpu_en;
    bit            toggle_ready;
    bit            stall_pending;
    logic [AW-1:0] stall_idx;
    logic [DW-1:0] stall_data;
    int            total = 0;
    int            bad   = 0;
    int            writes_seen;
    int            hold_low_seen;

    regfile_debug_ctrl #(
        .REGISTERS (REGS),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RUN_WIDTH (RW)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Start        (Start),
        .Mode         (Mode),
        .Seed         (Seed),
        .RunCycles    (RunCycles),
        .CpuHold      (CpuHold),
        .RfWriteEnable(RfWriteEnable),
        .RfWriteAddr  (RfWriteAddr),
        .RfWriteData  (RfWriteData),
        .RfReadAddr   (RfReadAddr),
        .RfReadData   (RfReadData),
        .DumpValid    (DumpValid),
        .DumpReady    (DumpReady),
        .DumpIndex    (DumpIndex),
        .DumpData     (DumpData),
        .Busy         (Busy),
        .Done         (Done)
    );

    always #5 Clock = ~Clock;

    // Register file with a combinational read port; the stub CPU bumps reg[1] while released.
    assign RfReadData = rf[RfReadAddr];

    always @(posedge Clock) begin
        if (RfWriteEnable === 1'b1) begin
            rf[RfWriteAddr] <= RfWriteData;
        end else if (cpu_en && CpuHold === 1'b0) begin
            rf[1] <= rf[1] + 32'd1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // DumpReady driver: constant 1, or the repeating 1,0,0,1 pattern.
    initial begin
        int k;
        k = 0;
        DumpReady = 1'b1;
        forever begin
            @(posedge Clock);
            #1;
            if (toggle_ready) begin
                DumpReady = (k % 4 == 0) || (k % 4 == 3);
                k++;
            end else begin
                DumpReady = 1'b1;
            end
        end
    end

    // Monitor: samples on the falling edge, pops the scoreboard on each transfer.
    initial begin
        dump_t e;
        forever begin
            @(negedge Clock);
            if (RfWriteEnable === 1'b1) writes_seen++;
            if (Busy === 1'b1 && CpuHold === 1'b0) hold_low_seen++;
            if (Done === 1'b1) check("done_no_valid", {63'd0, DumpValid}, 64'd0);
            if (stall_pending) begin
                check("stall_idx", {59'd0, DumpIndex}, {59'd0, stall_idx});
                check("stall_data", {32'd0, DumpData}, {32'd0, stall_data});
                stall_pending = 1'b0;
            end
            if (DumpValid === 1'b1 && DumpReady === 1'b0) begin
                stall_pending = 1'b1;
                stall_idx     = DumpIndex;
                stall_data    = DumpData;
            end
            if (DumpValid === 1'b1 && DumpReady === 1'b1) begin
                check("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("dump_idx", {59'd0, DumpIndex}, {59'd0, e.idx});
                    check("dump_data", {32'd0, DumpData}, {32'd0, e.data});
                end
            end
        end
    end

    task automatic push_exp(input int i, input logic [DW-1:0] d);
        dump_t e;
        e.idx  = AW'(i);
        e.data = d;
        sb.push_back(e);
    endtask

    // Issues Start (held for start_len cycles), optionally re-pulses it at cycle poke,
    // waits for Done and checks latency, write count and released-cycle count.
    task automatic run_seq(input logic [1:0] m, input logic [DW-1:0] s, input logic [RW-1:0] rc,
                           input bit stub, input int start_len, input int poke,
                           input int exp_lat, input int exp_writes, input int exp_hold);
        int cycles;
        writes_seen   = 0;
        hold_low_seen = 0;
        Mode      = m;
        Seed      = s;
        RunCycles = rc;
        Start     = 1'b1;
        cycles    = 0;
        do begin
            @(posedge Clock);
            #1;
            cycles++;
            Start = (cycles < start_len) || (cycles == poke);
            if (cycles == poke) Mode = 2'd1;
            if (cycles == 1) begin
                if (stub) cpu_en = 1'b1;
                check("done_drop", {63'd0, Done}, 64'd0);
                check("busy_rise", {63'd0, Busy}, 64'd1);
            end
        end while (Done !== 1'b1 && cycles < 3000);
        cpu_en = 1'b0;
        Start  = 1'b0;
        check("done_reached", {63'd0, Done}, 64'd1);
        if (exp_lat >= 0) check("latency", 64'(cycles), 64'(exp_lat));
        check("write_count", 64'(writes_seen), 64'(exp_writes));
        check("hold_low_cycles", 64'(hold_low_seen), 64'(exp_hold));
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int n;
        Reset         = 1'b1;
        Start         = 1'b0;
        Mode          = 2'd0;
        Seed          = '0;
        RunCycles     = '0;
        cpu_en        = 1'b0;
        toggle_ready  = 1'b0;
        stall_pending = 1'b0;
        writes_seen   = 0;
        hold_low_seen = 0;
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;

        check("rst_cpuhold", {63'd0, CpuHold}, 64'd0);
        check("rst_we", {63'd0, RfWriteEnable}, 64'd0);
        check("rst_valid", {63'd0, DumpValid}, 64'd0);
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_done", {63'd0, Done}, 64'd0);
        check("rst_waddr", {59'd0, RfWriteAddr}, 64'd0);
        check("rst_raddr", {59'd0, RfReadAddr}, 64'd0);
        check("rst_dumpidx", {59'd0, DumpIndex}, 64'd0);
        check("rst_wdata", {32'd0, RfWriteData}, 64'd0);

        // Index pattern, no run: Done 65 cycles after Start.
        for (int i = 0; i < REGS; i++) push_exp(i, DW'(i));
        run_seq(2'd0, '0, 16'd0, 1'b0, 1, -1, 65, 32, 0);

        // No preload, 6 run cycles: only reg[1] moves (1 -> 7).
        for (int i = 0; i < REGS; i++) push_exp(i, (i == 1) ? 32'd7 : DW'(i));
        run_seq(2'd3, '0, 16'd6, 1'b1, 1, -1, 39, 0, 6);

        // Seed pattern wrapping past 2^32, with an ignored Start pulse in RUN.
        for (int i = 0; i < REGS; i++) push_exp(i, 32'hFFFF_FFF0 + DW'(i));
        run_seq(2'd2, 32'hFFFF_FFF0, 16'd5, 1'b0, 1, 34, 70, 32, 5);
        check("wrap_r15", {32'd0, rf[15]}, 64'h0000_0000_FFFF_FFFF);
        check("wrap_r16", {32'd0, rf[16]}, 64'd0);

        // Back-pressured dump with DumpReady pattern 1,0,0,1.
        toggle_ready = 1'b1;
        for (int i = 0; i < REGS; i++) push_exp(i, DW'(i));
        run_seq(2'd0, '0, 16'd2, 1'b0, 1, -1, -1, 32, 2);
        toggle_ready = 1'b0;

        // Restart from DONE with Start held, zero pattern (Seed must be ignored).
        for (int i = 0; i < REGS; i++) push_exp(i, '0);
        run_seq(2'd1, 32'h1234, 16'd3, 1'b0, 4, -1, 68, 32, 3);

        // Reset pulse in the middle of RUN aborts the sequence.
        Mode      = 2'd2;
        Seed      = 32'd5;
        RunCycles = 16'd10;
        Start     = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        n = 0;
        while (!(Busy === 1'b1 && CpuHold === 1'b0) && n < 100) begin
            @(posedge Clock);
            #1;
            n++;
        end
        check("reach_run", {63'd0, Busy === 1'b1 && CpuHold === 1'b0}, 64'd1);
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        check("abort_busy", {63'd0, Busy}, 64'd0);
        check("abort_cpuhold", {63'd0, CpuHold}, 64'd0);
        check("abort_done", {63'd0, Done}, 64'd0);
        check("abort_valid", {63'd0, DumpValid}, 64'd0);
        check("abort_we", {63'd0, RfWriteEnable}, 64'd0);
        repeat (3) @(posedge Clock);
        #1;
        check("stay_idle", {63'd0, Busy}, 64'd0);
        check("sb_final", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
